// File: rtl/ceres_clint_mh.sv
// Multi-hart core-local interruptor: one shared prescaled mtime, per-hart mtimecmp/msip
// and IRQ outputs, behind a registered single-beat request/response slave port.
module ceres_clint_mh #(
  parameter int unsigned        NUM_HARTS = 1,
  parameter int unsigned        PRESC_W   = 16,
  parameter logic [PRESC_W-1:0] PRESC_RST = '0,
  parameter int unsigned        MTIME_W   = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  input  logic [15:0]          req_addr_i,
  input  logic                 req_we_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  input  logic                 time_stop_i,
  output logic [NUM_HARTS-1:0] mtip_o,
  output logic [NUM_HARTS-1:0] msip_o,
  output logic [MTIME_W-1:0]   mtime_o
);

  localparam int unsigned HIDX_W      = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam logic [2:0]  SHADOW_LIFE = 3'd4;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_PRESC,
    SEL_MTIME_LO,
    SEL_MTIME_HI
  } sel_e;

  logic [MTIME_W-1:0] mtime_q;
  logic [MTIME_W-1:0] mtimecmp_q [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt_q;
  logic [31:0]        shadow_q;
  logic [2:0]         shadow_cnt_q;

  sel_e              sel;
  logic [HIDX_W-1:0] hart;
  logic [31:0]       cur_word;
  logic [31:0]       merged_word;
  logic [31:0]       rdata;
  logic              wr_en;
  logic              rd_en;
  logic              presc_wr;
  logic              presc_hit;
  logic              tick;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr_i[1:0];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    sel  = SEL_NONE;
    hart = '0;
    if (req_addr_i[15:14] == 2'b00 && {20'd0, req_addr_i[13:2]} < NUM_HARTS) begin
      sel  = SEL_MSIP;
      hart = req_addr_i[2 +: HIDX_W];
    end else if (req_addr_i[15:14] == 2'b01 && {21'd0, req_addr_i[13:3]} < NUM_HARTS) begin
      sel  = req_addr_i[2] ? SEL_CMP_HI : SEL_CMP_LO;
      hart = req_addr_i[3 +: HIDX_W];
    end else begin
      case (req_addr_i[15:2])
        14'h2FFC: sel = SEL_PRESC;
        14'h2FFE: sel = SEL_MTIME_LO;
        14'h2FFF: sel = SEL_MTIME_HI;
        default:  sel = SEL_NONE;
      endcase
    end
  end

  // Live value of the addressed word; writes merge into it and reads return it.
  always_comb begin
    cur_word = '0;
    case (sel)
      SEL_MSIP:     cur_word[0] = msip_q[hart];
      SEL_CMP_LO:   cur_word = mtimecmp_q[hart][31:0];
      SEL_CMP_HI:   cur_word = mtimecmp_q[hart][63:32];
      SEL_PRESC:    cur_word[PRESC_W-1:0] = presc_q;
      SEL_MTIME_LO: cur_word = mtime_q[31:0];
      SEL_MTIME_HI: cur_word = mtime_q[63:32];
      default:      cur_word = '0;
    endcase
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (req_wstrb_i[b]) merged_word[8*b +: 8] = req_wdata_i[8*b +: 8];
    end
    rdata = cur_word;
    if (sel == SEL_MTIME_HI && shadow_cnt_q != '0) rdata = shadow_q;
  end

  assign wr_en     = req_valid_i && req_we_i && sel != SEL_NONE;
  assign rd_en     = req_valid_i && !req_we_i && sel != SEL_NONE;
  assign presc_wr  = wr_en && sel == SEL_PRESC;
  assign presc_hit = presc_cnt_q == presc_q;
  assign tick      = !time_stop_i && presc_hit && !presc_wr;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q      <= '0;
      presc_cnt_q  <= '0;
      presc_q      <= PRESC_RST;
      msip_q       <= '0;
      // NOTE: mtimecmp is a handful of flops, not a RAM, so it is reset like any register.
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
      shadow_q     <= '0;
      shadow_cnt_q <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      rsp_err_o    <= 1'b0;
      mtip_o       <= '0;
      msip_o       <= '0;
    end else begin
      if (presc_wr) begin
        presc_q     <= merged_word[PRESC_W-1:0];
        presc_cnt_q <= '0;
      end else if (!time_stop_i) begin
        presc_cnt_q <= presc_hit ? '0 : presc_cnt_q + PRESC_W'(1);
      end

      // A software write to either mtime word replaces that cycle's tick entirely.
      if (wr_en && sel == SEL_MTIME_LO)      mtime_q[31:0]  <= merged_word;
      else if (wr_en && sel == SEL_MTIME_HI) mtime_q[63:32] <= merged_word;
      else if (tick)                         mtime_q        <= mtime_q + MTIME_W'(1);

      if (wr_en && sel == SEL_MSIP)   msip_q[hart]             <= merged_word[0];
      if (wr_en && sel == SEL_CMP_LO) mtimecmp_q[hart][31:0]  <= merged_word;
      if (wr_en && sel == SEL_CMP_HI) mtimecmp_q[hart][63:32] <= merged_word;

      if (wr_en && (sel == SEL_MTIME_LO || sel == SEL_MTIME_HI)) begin
        shadow_cnt_q <= '0;
      end else if (rd_en && sel == SEL_MTIME_LO) begin
        shadow_q     <= mtime_q[63:32];
        shadow_cnt_q <= SHADOW_LIFE;
      end else if (shadow_cnt_q != '0) begin
        shadow_cnt_q <= shadow_cnt_q - 3'd1;
      end

      rsp_valid_o <= req_valid_i;
      rsp_err_o   <= req_valid_i && sel == SEL_NONE;
      rsp_rdata_o <= rd_en ? rdata : '0;

      for (int h = 0; h < NUM_HARTS; h++) mtip_o[h] <= mtime_q >= mtimecmp_q[h];
      msip_o <= msip_q;
    end
  end

  assign mtime_o = mtime_q;

endmodule

// File: tb/tb_ceres_clint_mh.sv
// Directed plus randomized bench for ceres_clint_mh (two harts, undivided reset prescaler)
// against a transaction-level reference model.
module tb_ceres_clint_mh;

  localparam int NH = 2;

  localparam int K_ERR  = 0;
  localparam int K_MSIP = 1;
  localparam int K_CLO  = 2;
  localparam int K_CHI  = 3;
  localparam int K_PRE  = 4;
  localparam int K_TLO  = 5;
  localparam int K_THI  = 6;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic [15:0]   req_addr_i = '0;
  logic          req_we_i = 1'b0;
  logic [31:0]   req_wdata_i = '0;
  logic [3:0]    req_wstrb_i = '0;
  logic          rsp_valid_o;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          time_stop_i = 1'b0;
  logic [NH-1:0] mtip_o;
  logic [NH-1:0] msip_o;
  logic [63:0]   mtime_o;

  ceres_clint_mh #(
    .NUM_HARTS (NH),
    .PRESC_W   (16),
    .PRESC_RST (16'h0000),
    .MTIME_W   (64)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .time_stop_i (time_stop_i),
    .mtip_o      (mtip_o),
    .msip_o      (msip_o),
    .mtime_o     (mtime_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: plain counters and integers, updated once per clock.
  longint unsigned m_time;
  longint unsigned m_cmp [NH];
  logic [NH-1:0]   m_msip;
  int unsigned     m_presc;
  int unsigned     m_cnt;
  logic [31:0]     m_shadow;
  int              m_cyc = 0;
  int              m_lo_rd_cyc = -100;

  logic          e_valid;
  logic          e_err;
  logic [31:0]   e_rdata;
  logic [NH-1:0] e_mtip;
  logic [NH-1:0] e_msip;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int          a;
    int          kind;
    int          h;
    bit          tk;
    logic [31:0] cur;
    logic [31:0] nw;
    m_cyc++;
    if (rst_i) begin
      m_time  = 0;
      m_cnt   = 0;
      m_presc = 0;
      m_msip  = '0;
      for (int i = 0; i < NH; i++) m_cmp[i] = '1;
      m_lo_rd_cyc = -100;
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_rdata = '0;
      e_mtip  = '0;
      e_msip  = '0;
      return;
    end
    for (int i = 0; i < NH; i++) e_mtip[i] = m_time >= m_cmp[i];
    e_msip  = m_msip;
    e_valid = req_valid_i;
    e_err   = 1'b0;
    e_rdata = '0;

    a = int'({16'd0, req_addr_i}) & 32'h0000_FFFC;
    h = 0;
    if (a < 4 * NH) begin
      kind = K_MSIP;
      h    = a / 4;
    end else if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
      h    = (a - 'h4000) / 8;
      kind = ((a - 'h4000) % 8 == 4) ? K_CHI : K_CLO;
    end else if (a == 'hBFF0) kind = K_PRE;
    else if (a == 'hBFF8) kind = K_TLO;
    else if (a == 'hBFFC) kind = K_THI;
    else kind = K_ERR;

    case (kind)
      K_MSIP:  cur = {31'd0, m_msip[h]};
      K_CLO:   cur = m_cmp[h][31:0];
      K_CHI:   cur = m_cmp[h][63:32];
      K_PRE:   cur = m_presc;
      K_TLO:   cur = m_time[31:0];
      K_THI:   cur = m_time[63:32];
      default: cur = '0;
    endcase
    nw = cur;
    for (int b = 0; b < 4; b++) if (req_wstrb_i[b]) nw[8*b +: 8] = req_wdata_i[8*b +: 8];

    if (req_valid_i && kind == K_ERR) e_err = 1'b1;
    if (req_valid_i && !req_we_i && kind != K_ERR) begin
      e_rdata = cur;
      if (kind == K_THI && m_cyc - m_lo_rd_cyc <= 4) e_rdata = m_shadow;
      if (kind == K_TLO) begin
        m_shadow    = m_time[63:32];
        m_lo_rd_cyc = m_cyc;
      end
    end

    tk = 1'b0;
    if (req_valid_i && req_we_i && kind == K_PRE) begin
      m_presc = nw & 32'h0000_FFFF;
      m_cnt   = 0;
    end else if (!time_stop_i) begin
      if (m_cnt == m_presc) begin
        m_cnt = 0;
        tk    = 1'b1;
      end else begin
        m_cnt++;
      end
    end

    if (req_valid_i && req_we_i && (kind == K_TLO || kind == K_THI)) begin
      if (kind == K_TLO) m_time[31:0] = nw;
      else               m_time[63:32] = nw;
      m_lo_rd_cyc = -100;
    end else if (tk) begin
      m_time = m_time + 1;
    end
    if (req_valid_i && req_we_i) begin
      if (kind == K_MSIP) m_msip[h] = nw[0];
      if (kind == K_CLO)  m_cmp[h][31:0] = nw;
      if (kind == K_CHI)  m_cmp[h][63:32] = nw;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
    check("rsp_valid", 64'(rsp_valid_o), 64'(e_valid));
    check("rsp_err",   64'(rsp_err_o),   64'(e_err));
    check("rsp_rdata", 64'(rsp_rdata_o), 64'(e_rdata));
    check("mtime",     mtime_o,          m_time);
    check("mtip",      64'(mtip_o),      64'(e_mtip));
    check("msip",      64'(msip_o),      64'(e_msip));
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] data,
                     input logic [3:0] strb);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = data;
    req_wstrb_i = strb;
    tick();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
  endtask

  logic [15:0] addr_pool [12];

  initial begin
    addr_pool = '{16'h0000, 16'h0004, 16'h0008, 16'h4000, 16'h4004, 16'h4008,
                  16'h400C, 16'h4010, 16'hBFF0, 16'hBFF4, 16'hBFF8, 16'hBFFC};

    // Reset state
    rst_i = 1'b1;
    idle(2);
    check("reset_mtime", mtime_o, 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset_mtip", 64'(mtip_o), 64'd0);
    rst_i = 1'b0;

    // Undivided count, then an mtime read sees the request-edge value
    idle(10);
    check("count10", mtime_o, 64'd10);
    bus(1'b0, 16'hBFF8, '0, 4'h0);
    check("rd_mtime_valid", 64'(rsp_valid_o), 64'd1);
    check("rd_mtime_data", 64'(rsp_rdata_o), 64'd10);

    // Prescaler of 3 -> one tick per 4 clocks; then debug halt
    bus(1'b1, 16'hBFF0, 32'd3, 4'hF);
    idle(12);
    check("presc3_mtime", mtime_o, 64'd14);
    time_stop_i = 1'b1;
    idle(8);
    check("stopped_mtime", mtime_o, 64'd14);
    time_stop_i = 1'b0;

    // Timer compare on hart 1 only
    bus(1'b1, 16'hBFF0, 32'd0, 4'hF);
    bus(1'b1, 16'h4008, 32'h20, 4'hF);
    bus(1'b1, 16'h400C, 32'h0, 4'hF);
    for (int i = 0; i < 100 && mtime_o != 64'h20; i++) idle(1);
    check("mtime_at_cmp", mtime_o, 64'h20);
    check("mtip_before", 64'(mtip_o), 64'd0);
    idle(1);
    check("mtip_after", 64'(mtip_o), 64'h2);

    // Atomic mtime read across a low-word carry
    bus(1'b1, 16'hBFFC, 32'h0, 4'hF);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    bus(1'b0, 16'hBFF8, '0, 4'h0);
    check("rd_lo", 64'(rsp_rdata_o), 64'hFFFF_FFFF);
    idle(1);
    bus(1'b0, 16'hBFFC, '0, 4'h0);
    check("rd_hi_shadow", 64'(rsp_rdata_o), 64'd0);
    check("mtime_carried", 64'(mtime_o[63:32]), 64'd1);
    idle(5);
    bus(1'b0, 16'hBFFC, '0, 4'h0);
    check("rd_hi_live", 64'(rsp_rdata_o), 64'd1);

    // Software IRQ and an out-of-range hart
    bus(1'b1, 16'h0004, 32'h1, 4'h1);
    idle(1);
    check("msip_o", 64'(msip_o), 64'h2);
    bus(1'b0, 16'h0008, '0, 4'h0);
    check("err_hart2", 64'(rsp_err_o), 64'd1);
    check("err_rdata", 64'(rsp_rdata_o), 64'd0);

    // Reset mid-count with a request pending
    rst_i       = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i  = 16'hBFF8;
    tick();
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    check("rst_mtime", mtime_o, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_irqs", 64'({mtip_o, msip_o}), 64'd0);
    bus(1'b0, 16'h4008, '0, 4'h0);
    check("rst_cmp_lo", 64'(rsp_rdata_o), 64'hFFFF_FFFF);
    bus(1'b0, 16'h400C, '0, 4'h0);
    check("rst_cmp_hi", 64'(rsp_rdata_o), 64'hFFFF_FFFF);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      logic [15:0] ra;
      sel = $urandom_range(0, 12);
      ra  = (sel == 12) ? 16'($urandom) : addr_pool[sel];
      ra[1:0] = 2'($urandom_range(0, 3));
      rst_i       = ($urandom_range(0, 99) == 0);
      time_stop_i = ($urandom_range(0, 7) == 0);
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_we_i    = $urandom_range(0, 1) == 1;
      req_addr_i  = ra;
      req_wstrb_i = 4'($urandom);
      if (ra[15:2] == 14'h2FFC)        req_wdata_i = $urandom_range(0, 3);
      else if ($urandom_range(0, 1) == 1) req_wdata_i = $urandom_range(0, 96);
      else                             req_wdata_i = $urandom;
      tick();
    end
    rst_i       = 1'b0;
    time_stop_i = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
